tetris_grid_utils: RTL and testbench

- Shared geometry and random-number helper for the Tetris VGA playfield.
- Combines three functions:
  - a 13-bit maximal-length LFSR used for piece-type selection;
  - a per-pixel playfield border detector driven by the raster X coordinate;
  - a reference-coordinate to grid-index converter for the 10x30 cell grid (300 cells, row-major, row 0 at screen top).
- Sits beside the VGA controller: the LFSR is clocked by the pixel clock; the border and index paths are purely combinational.

---
 rtl/tetris_grid_utils.sv | 113 +++++++++++
 tb/tb_tetris_grid_utils.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/tetris_grid_utils.sv
`default_nettype none
// ============================================================================
// Module   : tetris_grid_utils
// Brief    : Playfield helpers for the Tetris VGA path: a 13-bit maximal-
//            length LFSR (piece selection), a raster border-strip detector
//            and a reference-pixel to 10x30 grid-index converter.
// Revision : 1.0 - initial release
// ============================================================================
module tetris_grid_utils #(
    parameter logic [12:0] LFSR_SEED = 13'h0001,
    parameter int          FIELD_X0  = 240,
    parameter int          CELL      = 16,
    parameter int          COLS      = 10,
    parameter int          ROWS      = 30,
    parameter int          BORDER_W  = 16
) (
    input  logic        iVGA_CLK,
    input  logic        iRST_n,
    input  logic        lfsr_en,
    output logic [12:0] rand_out,
    output logic [2:0]  rand_mod5,
    input  logic [9:0]  addr_x,
    output logic        en_border,
    input  logic [9:0]  ref_x,
    input  logic [9:0]  ref_y,
    output logic [8:0]  grid_num,
    output logic        grid_valid
);

    // Playfield geometry in raster pixels. CELL is 16, so the cell index of
    // a pixel offset is simply its bits [9:4].
    localparam logic [9:0] C_X0      = 10'(FIELD_X0);
    localparam logic [9:0] C_X1      = 10'(FIELD_X0 + COLS * CELL);
    localparam logic [9:0] C_Y_END   = 10'(ROWS * CELL);
    localparam logic [9:0] C_BL_LO   = 10'(FIELD_X0 - BORDER_W);
    localparam logic [9:0] C_BL_HI   = 10'(FIELD_X0 - 1);
    localparam logic [9:0] C_BR_LO   = 10'(FIELD_X0 + COLS * CELL);
    localparam logic [9:0] C_BR_HI   = 10'(FIELD_X0 + COLS * CELL + BORDER_W - 1);
    localparam logic [12:0] C_RECOVER = 13'h0001;

    logic [12:0] lfsr_q;
    logic [12:0] lfsr_d;
    logic        w_fb;
    logic [12:0] w_mod5_full;

    logic [9:0]  w_dx;
    logic [8:0]  w_row;
    logic [8:0]  w_col;
    logic [8:0]  w_row_x10;
    logic        w_in_x;
    logic        w_in_y;

    // Taps for x^13+x^4+x^3+x+1 in Fibonacci form.
    assign w_fb = lfsr_q[12] ^ lfsr_q[3] ^ lfsr_q[2] ^ lfsr_q[0];

    // Next LFSR state: shift when enabled, and escape the illegal all-zero
    // lock-up state should it ever be reached (e.g. after an upset).
    always_comb begin
        lfsr_d = lfsr_q;
        if (lfsr_en) begin
            if (lfsr_q == 13'h0000) begin
                lfsr_d = C_RECOVER;
            end else begin
                lfsr_d = {lfsr_q[11:0], w_fb};
            end
        end
    end

    // LFSR state register; reset loads the seed immediately.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign rand_out    = lfsr_q;
    assign w_mod5_full = lfsr_q % 13'd5;
    assign rand_mod5   = w_mod5_full[2:0];

    // Border strips immediately left and right of the playfield.
    always_comb begin
        en_border = ((addr_x >= C_BL_LO) && (addr_x <= C_BL_HI)) ||
                    ((addr_x >= C_BR_LO) && (addr_x <= C_BR_HI));
    end

    // Range qualification; the index is forced to 0 outside the field so
    // the underflowed subtraction never reaches grid_num.
    assign w_in_x     = (ref_x >= C_X0) && (ref_x < C_X1);
    assign w_in_y     = (ref_y < C_Y_END);
    assign grid_valid = w_in_x && w_in_y;

    assign w_dx      = ref_x - C_X0;
    assign w_col     = {5'd0, w_dx[7:4]};
    assign w_row     = {4'd0, ref_y[8:4]};
    assign w_row_x10 = (w_row << 3) + (w_row << 1);

    // Row-major linear cell index, 10 cells per row.
    always_comb begin
        grid_num = 9'd0;
        if (grid_valid) begin
            grid_num = w_row_x10 + w_col;
        end
    end

    // Sub-cell pixel bits and bits that are zero whenever the index is valid.
    logic w_unused;
    assign w_unused = &{1'b0, w_dx[9:8], w_dx[3:0], ref_y[9], ref_y[3:0],
                        w_mod5_full[12:3]};

endmodule
`default_nettype wire

// File: tb/tb_tetris_grid_utils.sv
`default_nettype none
// ============================================================================
// Module   : tb_tetris_grid_utils
// Brief    : Directed self-checking bench for tetris_grid_utils.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tetris_grid_utils;

    logic        clk;
    logic        rst_n;
    logic        lfsr_en;
    logic [12:0] rand_out;
    logic [2:0]  rand_mod5;
    logic [9:0]  addr_x;
    logic        en_border;
    logic [9:0]  ref_x;
    logic [9:0]  ref_y;
    logic [8:0]  grid_num;
    logic        grid_valid;

    int checks   = 0;
    int failures = 0;

    tetris_grid_utils u_dut (
        .iVGA_CLK   (clk),
        .iRST_n     (rst_n),
        .lfsr_en    (lfsr_en),
        .rand_out   (rand_out),
        .rand_mod5  (rand_mod5),
        .addr_x     (addr_x),
        .en_border  (en_border),
        .ref_x      (ref_x),
        .ref_y      (ref_y),
        .grid_num   (grid_num),
        .grid_valid (grid_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference LFSR step, independent of the design.
    function automatic logic [12:0] lfsr_step(input logic [12:0] s);
        return {s[11:0], s[12] ^ s[3] ^ s[2] ^ s[0]};
    endfunction

    // Directed vectors.
    int unsigned seq_exp [4] = '{32'h0001, 32'h0003, 32'h0007, 32'h000E};
    int unsigned seq_m5  [4] = '{1, 3, 2, 4};
    int unsigned bx      [8] = '{223, 224, 239, 240, 399, 400, 415, 416};
    int unsigned bexp    [8] = '{0, 1, 1, 0, 0, 1, 1, 0};
    int unsigned gx      [7] = '{320, 240, 335, 384, 239, 400, 320};
    int unsigned gy      [7] = '{0, 0, 17, 464, 0, 16, 480};
    int unsigned gnum    [7] = '{5, 0, 15, 299, 0, 0, 0};
    int unsigned gval    [7] = '{1, 1, 1, 1, 0, 0, 0};

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [12:0] model;
        int          zeros;
        int          big_m5;
        int          early;
        int          mism;
        int          ones;
        int          bmism;
        logic        bref;

        rst_n   = 1'b0;
        lfsr_en = 1'b0;
        addr_x  = 10'd0;
        ref_x   = 10'd0;
        ref_y   = 10'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rand", 32'(rand_out), 32'h0001);
        chk("reset_mod5", 32'(rand_mod5), 32'd1);

        // Release reset with stepping enabled
        @(negedge clk);
        rst_n   = 1'b1;
        lfsr_en = 1'b1;
        #1;
        chk("seq0_rand", 32'(rand_out), seq_exp[0]);
        chk("seq0_mod5", 32'(rand_mod5), seq_m5[0]);
        for (int i = 1; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("seq%0d_rand", i), 32'(rand_out), seq_exp[i]);
            chk($sformatf("seq%0d_mod5", i), 32'(rand_mod5), seq_m5[i]);
        end

        // Hold with enable low
        lfsr_en = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("hold_rand", 32'(rand_out), 32'h000E);

        // Two more steps: 0x000E -> 0x001C -> 0x0038
        lfsr_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("resume_rand", 32'(rand_out), 32'h0038);

        // Asynchronous reset mid-cycle, no clock edge before the sample
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", 32'(rand_out), 32'h0001);
        @(negedge clk);
        rst_n = 1'b1;

        // Free-run a full period against the reference model
        model  = 13'h0001;
        zeros  = 0;
        big_m5 = 0;
        early  = 0;
        mism   = 0;
        for (int i = 0; i < 8191; i++) begin
            @(posedge clk);
            #1;
            model = lfsr_step(model);
            if (rand_out !== model) mism++;
            if (32'(rand_mod5) !== 32'(model % 13'd5)) mism++;
            if (rand_out == 13'h0000) zeros++;
            if (rand_mod5 > 3'd4) big_m5++;
            if ((i < 8190) && (rand_out == 13'h0001)) early++;
        end
        chk("period_end", 32'(rand_out), 32'h0001);
        chk("period_model", 32'(mism), 32'd0);
        chk("period_zero", 32'(zeros), 32'd0);
        chk("period_mod5", 32'(big_m5), 32'd0);
        chk("period_early", 32'(early), 32'd0);

        // Border sweep across the visible line
        ones  = 0;
        bmism = 0;
        for (int x = 0; x < 640; x++) begin
            addr_x = 10'(x);
            #1;
            bref = ((x >= 224) && (x <= 239)) || ((x >= 400) && (x <= 415));
            if (en_border !== bref) bmism++;
            if (en_border === 1'b1) ones++;
        end
        chk("border_sweep", 32'(bmism), 32'd0);
        chk("border_count", 32'(ones), 32'd32);
        for (int k = 0; k < 8; k++) begin
            addr_x = 10'(bx[k]);
            #1;
            chk($sformatf("border_x%0d", bx[k]), 32'(en_border), bexp[k]);
        end

        // Grid index conversion
        for (int k = 0; k < 7; k++) begin
            ref_x = 10'(gx[k]);
            ref_y = 10'(gy[k]);
            #1;
            chk($sformatf("gnum_%0d_%0d", gx[k], gy[k]), 32'(grid_num), gnum[k]);
            chk($sformatf("gval_%0d_%0d", gx[k], gy[k]), 32'(grid_valid), gval[k]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
